// File: rtl/sensor_pkg.sv
// Shared sensor IDs, FSM states and default timing constants
// for the ultrasonic/DHT start scheduler.
package sensor_pkg;

  typedef enum logic [1:0] {
    SENS_NONE  = 2'b00,
    SENS_ULTRA = 2'b01,
    SENS_DHT   = 2'b10
  } sens_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

  localparam int DEF_ULTRA_PERIOD_MS  = 100;
  localparam int DEF_DHT_PERIOD_MS    = 2000;
  localparam int DEF_ULTRA_TIMEOUT_MS = 30;
  localparam int DEF_DHT_TIMEOUT_MS   = 20;
  localparam int DEF_DHT_MIN_GAP_MS   = 1000;
  localparam int DEF_ERR_W            = 8;

  localparam int CNT_W = 16;

endpackage

// File: rtl/sensor_scheduler_if.sv
// Request/done/status bundle between the sensor scheduler (slave)
// and its environment (master): ticks, requests, dones, starts, status.
interface sensor_scheduler_if #(
  parameter int ERR_W = 8
);
  logic             imSec_Tick;
  logic             iAuto_En;
  logic             iReq_Ultra;
  logic             iReq_DHT;
  logic             iUltra_Done;
  logic             iDHT_Done;
  logic             oUltra_Start;
  logic             oDHT_Start;
  logic             oBusy;
  logic [1:0]       oActive;
  logic             oTimeout;
  logic [ERR_W-1:0] oErr_Cnt;

  modport master (
    output imSec_Tick, iAuto_En,
    output iReq_Ultra, iReq_DHT,
    output iUltra_Done, iDHT_Done,
    input  oUltra_Start, oDHT_Start,
    input  oBusy, oActive,
    input  oTimeout, oErr_Cnt
  );

  modport slave (
    input  imSec_Tick, iAuto_En,
    input  iReq_Ultra, iReq_DHT,
    input  iUltra_Done, iDHT_Done,
    output oUltra_Start, oDHT_Start,
    output oBusy, oActive,
    output oTimeout, oErr_Cnt
  );
endinterface

// File: rtl/ms_period_counter.sv
// Tick-driven modulo-PERIOD counter; held at 0 while disabled.
// Ports: clk, rst_n, en, tick in; wrap out (high on the wrapping tick).
module ms_period_counter #(
  parameter int PERIOD = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic tick,
  output logic wrap
);
  localparam int W = $clog2(PERIOD);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  assign wrap = en && tick && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end
endmodule

// File: rtl/sensor_scheduler.sv
// Arbitrates ultrasonic/DHT starts: pending flags, round-robin, DHT gap.
// Ports: iClk, iRst (async active-low), bus (sensor_scheduler_if.slave).
module sensor_scheduler
  import sensor_pkg::*;
#(
  parameter int ULTRA_PERIOD_MS  = DEF_ULTRA_PERIOD_MS,
  parameter int DHT_PERIOD_MS    = DEF_DHT_PERIOD_MS,
  parameter int ULTRA_TIMEOUT_MS = DEF_ULTRA_TIMEOUT_MS,
  parameter int DHT_TIMEOUT_MS   = DEF_DHT_TIMEOUT_MS,
  parameter int DHT_MIN_GAP_MS   = DEF_DHT_MIN_GAP_MS,
  parameter int ERR_W            = DEF_ERR_W
) (
  input logic iClk,
  input logic iRst,
  sensor_scheduler_if.slave bus
);
  localparam logic [CNT_W-1:0] GAP = CNT_W'(DHT_MIN_GAP_MS);
  localparam logic [CNT_W-1:0] UTO = CNT_W'(ULTRA_TIMEOUT_MS);
  localparam logic [CNT_W-1:0] DTO = CNT_W'(DHT_TIMEOUT_MS);

  state_t state, nextState;
  sens_t active, pick;

  logic ultraPend, dhtPend, lastDht;
  logic ultraWrap, dhtWrap;
  logic eligU, eligD, dhtReady;
  logic issueU, issueD;
  logic doneHit, toHit, timeoutNow;
  logic [CNT_W-1:0] gapCnt, toCnt, toLimit;
  logic uStart, dStart, busy, tOut;
  logic [ERR_W-1:0] errCnt;

  ms_period_counter #(.PERIOD(ULTRA_PERIOD_MS)) uUltraPer (
    .clk(iClk), .rst_n(iRst), .en(bus.iAuto_En),
    .tick(bus.imSec_Tick), .wrap(ultraWrap)
  );

  ms_period_counter #(.PERIOD(DHT_PERIOD_MS)) uDhtPer (
    .clk(iClk), .rst_n(iRst), .en(bus.iAuto_En),
    .tick(bus.imSec_Tick), .wrap(dhtWrap)
  );

  assign dhtReady = (gapCnt == GAP);
  assign eligU = ultraPend;
  assign eligD = dhtPend && dhtReady;
  assign issueU = (state == ST_ISSUE) && (active == SENS_ULTRA);
  assign issueD = (state == ST_ISSUE) && (active == SENS_DHT);

  assign doneHit =
    ((active == SENS_ULTRA) && bus.iUltra_Done) ||
    ((active == SENS_DHT) && bus.iDHT_Done);
  assign toLimit = (active == SENS_ULTRA) ? UTO : DTO;
  assign toHit = bus.imSec_Tick && (toCnt == toLimit - CNT_W'(1));

  // Round-robin only matters when both sensors are eligible.
  always_comb begin
    pick = SENS_NONE;
    unique case (1'b1)
      eligU && eligD:  pick = lastDht ? SENS_ULTRA : SENS_DHT;
      eligU && !eligD: pick = SENS_ULTRA;
      eligD && !eligU: pick = SENS_DHT;
      default: ;
    endcase
  end

  always_comb begin
    nextState = state;
    timeoutNow = 1'b0;
    unique case (state)
      ST_IDLE:  if (pick != SENS_NONE) nextState = ST_ISSUE;
      ST_ISSUE: nextState = ST_WAIT;
      ST_WAIT: begin
        if (doneHit) begin
          nextState = ST_IDLE;
        end else if (toHit) begin
          nextState = ST_IDLE;
          timeoutNow = 1'b1;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state <= ST_IDLE;
      active <= SENS_NONE;
    end else begin
      state <= nextState;
      if (nextState == ST_IDLE) active <= SENS_NONE;
      else if (state == ST_IDLE) active <= pick;
    end
  end

  // A new request in the issue cycle re-pends rather than being lost.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      ultraPend <= 1'b0;
      dhtPend <= 1'b0;
      lastDht <= 1'b1;
    end else begin
      ultraPend <= bus.iReq_Ultra | ultraWrap | (ultraPend & ~issueU);
      dhtPend <= bus.iReq_DHT | dhtWrap | (dhtPend & ~issueD);
      if (issueU) lastDht <= 1'b0;
      else if (issueD) lastDht <= 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      gapCnt <= GAP;
      toCnt <= '0;
    end else begin
      if (issueD) gapCnt <= '0;
      else if (bus.imSec_Tick && !dhtReady) gapCnt <= gapCnt + CNT_W'(1);
      if (state == ST_ISSUE) toCnt <= '0;
      else if (state == ST_WAIT && bus.imSec_Tick) toCnt <= toCnt + CNT_W'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      uStart <= 1'b0;
      dStart <= 1'b0;
      busy <= 1'b0;
      tOut <= 1'b0;
      errCnt <= '0;
    end else begin
      uStart <= (state == ST_IDLE) && (pick == SENS_ULTRA);
      dStart <= (state == ST_IDLE) && (pick == SENS_DHT);
      busy <= (nextState != ST_IDLE);
      tOut <= timeoutNow;
      if (timeoutNow && errCnt != '1) errCnt <= errCnt + ERR_W'(1);
    end
  end

  assign bus.oUltra_Start = uStart;
  assign bus.oDHT_Start = dStart;
  assign bus.oBusy = busy;
  assign bus.oActive = active;
  assign bus.oTimeout = tOut;
  assign bus.oErr_Cnt = errCnt;

endmodule

// File: tb/tb_sensor_scheduler.sv
// Scoreboard bench for sensor_scheduler: expected start/timeout events
// are queued with their cycle and matched against DUT pulses.
module tb_sensor_scheduler;

  localparam int TICK_DIV = 5;
  localparam int K_US = 0;
  localparam int K_DS = 1;
  localparam int K_TO = 2;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  sensor_scheduler_if #(.ERR_W(8)) bus ();

  sensor_scheduler #(
    .ULTRA_PERIOD_MS(5),
    .DHT_PERIOD_MS(2000),
    .ULTRA_TIMEOUT_MS(30),
    .DHT_TIMEOUT_MS(20),
    .DHT_MIN_GAP_MS(10),
    .ERR_W(8)
  ) dut (
    .iClk(clk),
    .iRst(rstN),
    .bus(bus)
  );

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t sb[$];
  int errors = 0;
  int checks = 0;
  int cycle = 0;
  bit tickOn = 0;
  bit autoDoneU = 0;
  bit autoDoneD = 0;

  // Event monitor: every start/timeout pulse must match the queue head.
  always @(negedge clk) begin
    ev_t e;
    logic hit;
    for (int k = 0; k < 3; k++) begin
      hit = (k == K_US) ? bus.oUltra_Start :
            (k == K_DS) ? bus.oDHT_Start : bus.oTimeout;
      if (hit === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL event: kind=%0d at cycle %0d, required no event",
                   k, cycle);
        end else begin
          e = sb.pop_front();
          if (e.kind !== k || e.at !== cycle) begin
            errors++;
            $display("FAIL event: kind=%0d cycle=%0d, required kind=%0d cycle=%0d",
                     k, cycle, e.kind, e.at);
          end
        end
      end
    end
  end

  task automatic cyc();
    logic us, ds;
    us = bus.oUltra_Start;
    ds = bus.oDHT_Start;
    @(posedge clk);
    #1;
    cycle++;
    bus.iReq_Ultra = 1'b0;
    bus.iReq_DHT = 1'b0;
    bus.iUltra_Done = 1'b0;
    bus.iDHT_Done = 1'b0;
    bus.imSec_Tick = tickOn && (cycle % TICK_DIV == 0);
    if (autoDoneU && us) bus.iUltra_Done = 1'b1;
    if (autoDoneD && ds) bus.iDHT_Done = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic apply_reset();
    rstN = 1'b0;
    tickOn = 0;
    autoDoneU = 0;
    autoDoneD = 0;
    bus.iAuto_En = 1'b0;
    run(3);
    rstN = 1'b1;
    run(2);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    run(2);
    checks++;
    if ({bus.oUltra_Start, bus.oDHT_Start, bus.oBusy, bus.oActive,
         bus.oTimeout, bus.oErr_Cnt} !== 14'd0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h, required 0", {bus.oUltra_Start,
               bus.oDHT_Start, bus.oBusy, bus.oActive, bus.oTimeout, bus.oErr_Cnt});
    end
    apply_reset();
    checks++;
    if ({bus.oUltra_Start, bus.oDHT_Start, bus.oBusy, bus.oActive,
         bus.oTimeout, bus.oErr_Cnt} !== 14'd0) begin
      errors++;
      $display("FAIL reset_release: outputs=%h, required 0", {bus.oUltra_Start,
               bus.oDHT_Start, bus.oBusy, bus.oActive, bus.oTimeout, bus.oErr_Cnt});
    end
  endtask

  task automatic test_single_ultra();
    apply_reset();
    run(10);
    bus.iReq_Ultra = 1'b1;
    sb.push_back('{K_US, cycle + 2});
    run(2);
    checks++;
    if (bus.oActive !== 2'b01) begin
      errors++;
      $display("FAIL single_active: got %b, required 01", bus.oActive);
    end
    checks++;
    if (bus.oBusy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got %b, required 1", bus.oBusy);
    end
    run(500);
    bus.iUltra_Done = 1'b1;
    cyc();
    checks++;
    if (bus.oBusy !== 1'b0 || bus.oActive !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: busy=%b active=%b, required 0 00",
               bus.oBusy, bus.oActive);
    end
    run(5);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL single_drain: %0d left, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    bus.iReq_Ultra = 1'b1;
    bus.iReq_DHT = 1'b1;
    sb.push_back('{K_US, cycle + 2});
    run(6);
    bus.iUltra_Done = 1'b1;
    sb.push_back('{K_DS, cycle + 2});
    run(3);
    checks++;
    if (bus.oActive !== 2'b10) begin
      errors++;
      $display("FAIL rr_active: got %b, required 10", bus.oActive);
    end
    bus.iDHT_Done = 1'b1;
    run(5);
    checks++;
    if (sb.size() != 0 || bus.oBusy !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain: left=%0d busy=%b, required 0 0",
               sb.size(), bus.oBusy);
      sb.delete();
    end
  endtask

  task automatic test_auto();
    int nt;
    apply_reset();
    autoDoneU = 1;
    bus.iAuto_En = 1'b1;
    tickOn = 1;
    nt = 0;
    while (nt < 50) begin
      cyc();
      if (bus.imSec_Tick) begin
        nt++;
        if (nt % 5 == 0) sb.push_back('{K_US, cycle + 2});
      end
    end
    run(10);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL auto_on: %0d starts missing, required 0", sb.size());
      sb.delete();
    end
    bus.iAuto_En = 1'b0;
    nt = 0;
    while (nt < 50) begin
      cyc();
      if (bus.imSec_Tick) nt++;
    end
    run(5);
    checks++;
    if (bus.oBusy !== 1'b0) begin
      errors++;
      $display("FAIL auto_off_busy: got %b, required 0", bus.oBusy);
    end
  endtask

  task automatic test_dht_gap();
    int s, nt;
    apply_reset();
    tickOn = 1;
    autoDoneD = 1;
    bus.iReq_DHT = 1'b1;
    s = cycle + 2;
    sb.push_back('{K_DS, s});
    nt = 0;
    while (nt < 10) begin
      cyc();
      if (bus.imSec_Tick && cycle > s) begin
        nt++;
        if (nt == 3) bus.iReq_DHT = 1'b1;
        if (nt == 10) sb.push_back('{K_DS, cycle + 2});
      end
    end
    run(20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL gap_drain: %0d left, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_timeout();
    int s, nt, expErr;
    apply_reset();
    tickOn = 1;
    for (int it = 1; it <= 300; it++) begin
      bus.iReq_DHT = 1'b1;
      s = cycle + 2;
      sb.push_back('{K_DS, s});
      nt = 0;
      while (nt < 20) begin
        cyc();
        if (bus.imSec_Tick && cycle > s) nt++;
      end
      sb.push_back('{K_TO, cycle + 1});
      cyc();
      expErr = (it < 255) ? it : 255;
      checks++;
      if (bus.oErr_Cnt !== 8'(expErr) || bus.oBusy !== 1'b0 ||
          bus.oActive !== 2'b00) begin
        errors++;
        $display("FAIL timeout_%0d: err=%0d busy=%b active=%b, required %0d 0 00",
                 it, bus.oErr_Cnt, bus.oBusy, bus.oActive, expErr);
      end
    end
    run(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout_drain: %0d left, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_done_wins();
    int s, nt;
    apply_reset();
    tickOn = 1;
    bus.iReq_Ultra = 1'b1;
    s = cycle + 2;
    sb.push_back('{K_US, s});
    nt = 0;
    while (nt < 30) begin
      cyc();
      if (bus.imSec_Tick && cycle > s) nt++;
    end
    bus.iUltra_Done = 1'b1;
    cyc();
    checks++;
    if (bus.oBusy !== 1'b0 || bus.oErr_Cnt !== 8'd0) begin
      errors++;
      $display("FAIL done_wins: busy=%b err=%0d, required 0 0",
               bus.oBusy, bus.oErr_Cnt);
    end
    run(10);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL done_wins_drain: %0d left, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    tickOn = 1;
    bus.iReq_DHT = 1'b1;
    sb.push_back('{K_DS, cycle + 2});
    run(5);
    bus.iReq_Ultra = 1'b1;
    run(3);
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if ({bus.oUltra_Start, bus.oDHT_Start, bus.oBusy, bus.oActive,
         bus.oTimeout, bus.oErr_Cnt} !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid: outputs=%h, required 0", {bus.oUltra_Start,
               bus.oDHT_Start, bus.oBusy, bus.oActive, bus.oTimeout, bus.oErr_Cnt});
    end
    run(3);
    rstN = 1'b1;
    run(60);
    checks++;
    if (sb.size() != 0 || bus.oBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: left=%0d busy=%b, required 0 0",
               sb.size(), bus.oBusy);
      sb.delete();
    end
  endtask

  initial begin
    bus.imSec_Tick = 1'b0;
    bus.iAuto_En = 1'b0;
    bus.iReq_Ultra = 1'b0;
    bus.iReq_DHT = 1'b0;
    bus.iUltra_Done = 1'b0;
    bus.iDHT_Done = 1'b0;
    test_reset();
    test_single_ultra();
    test_round_robin();
    test_auto();
    test_dht_gap();
    test_timeout();
    test_done_wins();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
